lp_label_unit: RTL

Commit-side landing-pad unit for the FCFI extension. It owns the landing-pad label register (LPLR) and the expected-landing-pad (ELP) state. It consumes the CSR-address-tagged landing-pad ops that the CSR buffer holds until commit, and indirect-jump commits from the commit stage. It returns the current LPLR for reads and a same-cycle landing-pad fault to the commit stage.

---
 rtl/lp_label_unit_pkg.sv | 43 ++++
 rtl/lp_label_unit_cmp.sv | 54 +++++
 rtl/lp_label_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lp_label_unit_pkg.sv
// Shared FCFI definitions: landing-pad fault causes, ELP states, LPLR field
// layout and the CSR_LPLR address. Also carries the slice of the core's
// fu_op enumeration that the landing-pad unit decodes, including the
// LPCML/LPCUL check ops.
package lp_label_unit_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        LPSLL = 4'd1,
        LPSML = 4'd2,
        LPSUL = 4'd3,
        LPCLL = 4'd4,
        LPCML = 4'd5,
        LPCUL = 4'd6
    } fu_op;

    typedef enum logic [1:0] {
        LP_NONE    = 2'd0,
        LP_MISSING = 2'd1,
        LP_LABEL   = 2'd2
    } lp_cause_e;

    typedef enum logic {
        NO_LP_EXP = 1'b0,
        LP_EXP    = 1'b1
    } elp_state_e;

    typedef enum logic [1:0] {
        FIELD_LL = 2'd0,
        FIELD_ML = 2'd1,
        FIELD_UL = 2'd2
    } lp_field_e;

    localparam int unsigned LPLR_LL_OFF = 0;
    localparam int unsigned LPLR_LL_W   = 9;
    localparam int unsigned LPLR_ML_OFF = 9;
    localparam int unsigned LPLR_ML_W   = 8;
    localparam int unsigned LPLR_UL_OFF = 17;
    localparam int unsigned LPLR_UL_W   = 8;

    localparam logic [11:0] CSR_LPLR = 12'h820;

endpackage

// File: rtl/lp_label_unit_cmp.sv
// lp_label_cmp: decodes a landing-pad op into the LPLR field it addresses,
// flags whether it is a set or check op, and compares that field against
// the label operand. Purely combinational.
module lp_label_cmp
    import lp_label_unit_pkg::*;
#(
    parameter int unsigned LBL_W = 25
) (
    input  logic [LBL_W-1:0] lplr_i,
    input  fu_op             op_i,
    input  logic [8:0]       label_i,
    output logic             is_set_o,
    output logic             is_check_o,
    output logic             match_o,
    output lp_field_e        field_idx_o
);

    logic [8:0] fieldVal;
    logic [8:0] labelVal;

    // Decode the op, pick the addressed field and compare it to the label
    always_comb begin
        is_set_o    = 1'b0;
        is_check_o  = 1'b0;
        field_idx_o = FIELD_LL;
        fieldVal    = '0;
        labelVal    = '0;
        case (op_i)
            LPSLL: begin is_set_o   = 1'b1; field_idx_o = FIELD_LL; end
            LPSML: begin is_set_o   = 1'b1; field_idx_o = FIELD_ML; end
            LPSUL: begin is_set_o   = 1'b1; field_idx_o = FIELD_UL; end
            LPCLL: begin is_check_o = 1'b1; field_idx_o = FIELD_LL; end
            LPCML: begin is_check_o = 1'b1; field_idx_o = FIELD_ML; end
            LPCUL: begin is_check_o = 1'b1; field_idx_o = FIELD_UL; end
            default: ;
        endcase
        case (field_idx_o)
            FIELD_ML: begin
                fieldVal = {1'b0, lplr_i[LPLR_ML_OFF +: LPLR_ML_W]};
                labelVal = {1'b0, label_i[7:0]};
            end
            FIELD_UL: begin
                fieldVal = {1'b0, lplr_i[LPLR_UL_OFF +: LPLR_UL_W]};
                labelVal = {1'b0, label_i[7:0]};
            end
            default: begin
                fieldVal = lplr_i[LPLR_LL_OFF +: LPLR_LL_W];
                labelVal = label_i;
            end
        endcase
        match_o = (fieldVal == labelVal);
    end

endmodule

// File: rtl/lp_label_unit.sv
// lp_label_unit: commit-side landing-pad unit. Holds the LPLR and the ELP
// state, applies committed set ops, checks committed check ops and raises a
// same-cycle landing-pad fault to the commit stage.
// Optional build macro FCFI_LP_STATS_EN adds saturating fault counters.
module lp_label_unit
    import lp_label_unit_pkg::*;
#(
    parameter int unsigned LBL_W = 25
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             commit_valid_i,
    input  fu_op             commit_op_i,
    input  logic [8:0]       commit_label_i,
    input  logic             commit_ind_jump_i,
    output logic             commit_ready_o,
    output logic             lp_fault_o,
    output lp_cause_e        lp_cause_o,
    input  logic             trap_i,
    input  logic             mret_i,
    input  logic             csr_we_i,
    input  logic [LBL_W-1:0] csr_wdata_i,
    output logic [LBL_W-1:0] lplr_o,
    output logic             elp_o,
`ifdef FCFI_LP_STATS_EN
    output logic [15:0]      lp_missing_cnt_o,
    output logic [15:0]      lp_label_cnt_o,
`endif
    output logic             pelp_o
);

    logic [LBL_W-1:0] lplr_q, lplr_d;
    elp_state_e       elp_q, elp_d;
    logic             pelp_q, pelp_d;
    logic             csrWeDly_q;

    logic      isSet;
    logic      isCheck;
    logic      labelMatch;
    lp_field_e fieldIdx;
    logic      commitAccept;
    logic      missingFault;
    logic      labelFault;
    logic      commitUpdate;

    lp_label_cmp #(
        .LBL_W (LBL_W)
    ) i_cmp (
        .lplr_i      (lplr_q),
        .op_i        (commit_op_i),
        .label_i     (commit_label_i),
        .is_set_o    (isSet),
        .is_check_o  (isCheck),
        .match_o     (labelMatch),
        .field_idx_o (fieldIdx)
    );

    assign commit_ready_o = ~csrWeDly_q;
    assign lplr_o         = lplr_q;
    assign elp_o          = (elp_q == LP_EXP);
    assign pelp_o         = pelp_q;

    // State registers; reset drops the unit back to NO_LP_EXP at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lplr_q     <= '0;
            elp_q      <= NO_LP_EXP;
            pelp_q     <= 1'b0;
            csrWeDly_q <= 1'b0;
        end else begin
            lplr_q     <= lplr_d;
            elp_q      <= elp_d;
            pelp_q     <= pelp_d;
            csrWeDly_q <= csr_we_i;
        end
    end

    // Fault detection, ELP next state and LPLR/PELP next values
    always_comb begin
        commitAccept = commit_valid_i & commit_ready_o & ~flush_i;
        missingFault = commitAccept & (elp_q == LP_EXP) & (commit_op_i != LPCLL);
        labelFault   = commitAccept & isCheck & ~labelMatch;
        lp_fault_o   = missingFault | labelFault;
        lp_cause_o   = LP_NONE;
        if (missingFault) begin
            lp_cause_o = LP_MISSING;
        end else if (labelFault) begin
            lp_cause_o = LP_LABEL;
        end
        commitUpdate = commitAccept & ~lp_fault_o & ~trap_i;

        lplr_d = csr_we_i ? csr_wdata_i : lplr_q;
        if (commitUpdate && isSet) begin
            case (fieldIdx)
                FIELD_ML: lplr_d[LPLR_ML_OFF +: LPLR_ML_W] = commit_label_i[7:0];
                FIELD_UL: lplr_d[LPLR_UL_OFF +: LPLR_UL_W] = commit_label_i[7:0];
                default:  lplr_d[LPLR_LL_OFF +: LPLR_LL_W] = commit_label_i;
            endcase
        end

        elp_d  = elp_q;
        pelp_d = pelp_q;
        if (trap_i) begin
            pelp_d = (elp_q == LP_EXP);
            elp_d  = NO_LP_EXP;
        end else begin
            if (commitUpdate) begin
                case (elp_q)
                    LP_EXP:    elp_d = NO_LP_EXP;
                    default:   elp_d = commit_ind_jump_i ? LP_EXP : NO_LP_EXP;
                endcase
            end
            if (mret_i) begin
                elp_d  = pelp_q ? LP_EXP : NO_LP_EXP;
                pelp_d = 1'b0;
            end
        end
    end

`ifdef FCFI_LP_STATS_EN
    // Saturating per-cause fault counters, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lp_missing_cnt_o <= '0;
            lp_label_cnt_o   <= '0;
        end else begin
            if (lp_fault_o && lp_cause_o == LP_MISSING && lp_missing_cnt_o != 16'hFFFF) begin
                lp_missing_cnt_o <= lp_missing_cnt_o + 16'd1;
            end
            if (lp_fault_o && lp_cause_o == LP_LABEL && lp_label_cnt_o != 16'hFFFF) begin
                lp_label_cnt_o <= lp_label_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
